// File: rtl/mod_add_serial_drv_if.sv
// Bundle of the request, adder-side serial and response signals of mod_add_serial_drv.
// slave = the driver itself, master = the environment (requester, serial adder, response sink).
interface mod_add_serial_drv_if #(
    parameter int WIDTH = 256
);
    logic             req_valid;
    logic             req_ready;
    logic [WIDTH-1:0] req_a;
    logic [WIDTH-1:0] req_b;
    logic [1:0]       req_sel;
    logic             nu_1;
    logic             nu_2;
    logic [1:0]       sel;
    logic             start_add;
    logic             add_nu;
    logic             done_add;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [WIDTH-1:0] rsp_data;
    logic             rsp_err;

    modport slave (
        input  req_valid, req_a, req_b, req_sel, add_nu, done_add, rsp_ready,
        output req_ready, nu_1, nu_2, sel, start_add, rsp_valid, rsp_data, rsp_err
    );

    modport master (
        output req_valid, req_a, req_b, req_sel, add_nu, done_add, rsp_ready,
        input  req_ready, nu_1, nu_2, sel, start_add, rsp_valid, rsp_data, rsp_err
    );
endinterface

// File: rtl/mod_add_serial_drv.sv
// Serial driver for a bit-serial adder: shifts operands out LSB first, pulses start, captures the serial result.
// Optional WAIT watchdog enabled by defining MOD_ADD_DRV_TIMEOUT_EN.
module mod_add_serial_drv #(
    parameter int WIDTH   = 256,
    parameter int TIMEOUT = 1024
) (
    input  logic                clk,
    input  logic                rst,
    mod_add_serial_drv_if.slave bus
);
    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SHIFT,
        S_START,
        S_WAIT,
        S_CAPT,
        S_RESP
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_res;
    logic [CW-1:0]    r_cnt;
    logic             r_nu1;
    logic             r_nu2;
    logic             r_start;
    logic             r_ready;
    logic             r_valid;
    logic [1:0]       r_sel;

`ifdef MOD_ADD_DRV_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] LAST_WAIT = TW'(TIMEOUT - 1);
    logic [TW-1:0] r_wd;
    logic          r_err;
`endif

    // r_a/r_b hold the bits still to be sent; the bit on nu_1/nu_2 was already popped off.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_a     <= '0;
            r_b     <= '0;
            r_res   <= '0;
            r_cnt   <= '0;
            r_nu1   <= 1'b0;
            r_nu2   <= 1'b0;
            r_start <= 1'b0;
            r_ready <= 1'b1;
            r_valid <= 1'b0;
            r_sel   <= 2'b00;
`ifdef MOD_ADD_DRV_TIMEOUT_EN
            r_wd    <= '0;
            r_err   <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.req_valid) begin
                        r_a     <= bus.req_a >> 1;
                        r_b     <= bus.req_b >> 1;
                        r_nu1   <= bus.req_a[0];
                        r_nu2   <= bus.req_b[0];
                        r_sel   <= bus.req_sel;
                        r_cnt   <= '0;
                        r_ready <= 1'b0;
`ifdef MOD_ADD_DRV_TIMEOUT_EN
                        r_err   <= 1'b0;
`endif
                        r_state <= S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    if (r_cnt == LAST_BIT) begin
                        r_nu1   <= 1'b0;
                        r_nu2   <= 1'b0;
                        r_start <= 1'b1;
                        r_state <= S_START;
                    end else begin
                        r_nu1 <= r_a[0];
                        r_nu2 <= r_b[0];
                        r_a   <= r_a >> 1;
                        r_b   <= r_b >> 1;
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                S_START: begin
                    r_start <= 1'b0;
`ifdef MOD_ADD_DRV_TIMEOUT_EN
                    r_wd    <= '0;
`endif
                    r_state <= S_WAIT;
                end
                S_WAIT: begin
                    if (bus.done_add) begin
                        r_cnt   <= '0;
                        r_state <= S_CAPT;
                    end
`ifdef MOD_ADD_DRV_TIMEOUT_EN
                    else if (r_wd == LAST_WAIT) begin
                        r_res   <= '0;
                        r_err   <= 1'b1;
                        r_valid <= 1'b1;
                        r_state <= S_RESP;
                    end else begin
                        r_wd <= r_wd + TW'(1);
                    end
`endif
                end
                // Result arrives LSB first, so shifting in at the MSB lands sample i on bit i.
                S_CAPT: begin
                    r_res <= {bus.add_nu, r_res[WIDTH-1:1]};
                    if (r_cnt == LAST_BIT) begin
                        r_valid <= 1'b1;
                        r_state <= S_RESP;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                S_RESP: begin
                    if (bus.rsp_ready) begin
                        r_valid <= 1'b0;
                        r_ready <= 1'b1;
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.req_ready = r_ready;
    assign bus.nu_1      = r_nu1;
    assign bus.nu_2      = r_nu2;
    assign bus.sel       = r_sel;
    assign bus.start_add = r_start;
    assign bus.rsp_valid = r_valid;
    assign bus.rsp_data  = r_res;
`ifdef MOD_ADD_DRV_TIMEOUT_EN
    assign bus.rsp_err   = r_err;
`else
    assign bus.rsp_err   = 1'b0;
`endif

endmodule

// File: tb/tb_mod_add_serial_drv.sv
// Testbench for mod_add_serial_drv: directed transactions against a behavioural serial adder,
// responses checked by a scoreboard queue; the watchdog case runs only with MOD_ADD_DRV_TIMEOUT_EN.
module tb_mod_add_serial_drv;
    localparam int W  = 256;
    localparam int TO = 16;

    typedef struct packed {
        logic [W-1:0] data;
        logic         err;
    } exp_t;

    logic clk;
    logic rst;
    logic modelDone;
    logic spuriousDone;
    logic addNu;
    logic modelEnable;
    int   modelDelay;
    logic [W-1:0] modelResult;

    int compared;
    int mismatched;
    exp_t sbQ[$];

    mod_add_serial_drv_if #(.WIDTH(W)) bus ();

    mod_add_serial_drv #(.WIDTH(W), .TIMEOUT(TO)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    assign bus.done_add = modelDone | spuriousDone;
    assign bus.add_nu   = addNu;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [W-1:0] actual, input logic [W-1:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
        end
    endtask

    // Pops the scoreboard on every response handshake; any response with nothing queued is a failure.
    task automatic runMonitor();
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst && bus.rsp_valid && bus.rsp_ready) begin
                if (sbQ.size() == 0) begin
                    compared++;
                    mismatched++;
                    $display("[TB] FAIL unexpected response: got data %h err %b expected no response",
                             bus.rsp_data, bus.rsp_err);
                end else begin
                    e = sbQ.pop_front();
                    checkOutput("rsp_data", bus.rsp_data, e.data);
                    checkOutput("rsp_err", W'(bus.rsp_err), W'(e.err));
                end
            end
        end
    endtask

    // Behavioural adder: done_add in the modelDelay-th WAIT cycle, then the result LSB first.
    task automatic runAdder();
        forever begin
            @(posedge clk);
            #1;
            if (bus.start_add && modelEnable) begin
                repeat (modelDelay) begin
                    @(posedge clk);
                    #1;
                end
                modelDone = 1'b1;
                @(posedge clk);
                #1;
                modelDone = 1'b0;
                for (int i = 0; i < W; i++) begin
                    addNu = modelResult[i];
                    @(posedge clk);
                    #1;
                end
                addNu = 1'b0;
            end
        end
    endtask

    task automatic waitReady();
        int n = 0;
        while (bus.req_ready !== 1'b1 && n < 4000) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (bus.req_ready !== 1'b1) checkOutput("req_ready wait", W'(bus.req_ready), W'(1));
    endtask

    // Issues one request, checks the serial stream and returns in the START cycle.
    task automatic applyStimulus(input logic [W-1:0] a, input logic [W-1:0] b, input logic [1:0] s,
                                 input logic [W-1:0] res, input logic expErr, input int delay,
                                 input int spuriousAt, input bit holdReady);
        logic [W-1:0] nu1v;
        logic [W-1:0] nu2v;
        logic sawStart;
        exp_t e;
        int n;
        waitReady();
        modelResult = res;
        modelDelay  = delay;
        modelEnable = (delay > 0);
        bus.rsp_ready = holdReady ? 1'b0 : 1'b1;
        e.data = res;
        e.err  = expErr;
        sbQ.push_back(e);
        bus.req_a     = a;
        bus.req_b     = b;
        bus.req_sel   = s;
        bus.req_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        checkOutput("req_ready busy", W'(bus.req_ready), W'(0));
        sawStart = 1'b0;
        for (int i = 0; i < W; i++) begin
            nu1v[i] = bus.nu_1;
            nu2v[i] = bus.nu_2;
            if (bus.start_add) sawStart = 1'b1;
            spuriousDone = (i == spuriousAt);
            @(posedge clk);
            #1;
        end
        spuriousDone = 1'b0;
        checkOutput("nu_1 stream", nu1v, a);
        checkOutput("nu_2 stream", nu2v, b);
        checkOutput("start_add during SHIFT", W'(sawStart), W'(0));
        checkOutput("start_add in START", W'(bus.start_add), W'(1));
        checkOutput("nu_1 after SHIFT", W'(bus.nu_1), W'(0));
        checkOutput("sel latched", W'(bus.sel), W'(s));
        if (holdReady) begin
            n = 0;
            while (!bus.rsp_valid && n < 4 * W) begin
                @(posedge clk);
                #1;
                n++;
            end
            for (int c = 0; c < 10; c++) begin
                checkOutput("stall rsp_valid", W'(bus.rsp_valid), W'(1));
                checkOutput("stall rsp_data", bus.rsp_data, res);
                checkOutput("stall req_ready", W'(bus.req_ready), W'(0));
                checkOutput("stall sel", W'(bus.sel), W'(s));
                bus.req_a     = ~a;
                bus.req_b     = ~b;
                bus.req_valid = (c == 3);
                @(posedge clk);
                #1;
            end
            bus.req_valid = 1'b0;
            bus.rsp_ready = 1'b1;
            @(posedge clk);
            #1;
            checkOutput("post-handshake rsp_valid", W'(bus.rsp_valid), W'(0));
            checkOutput("post-handshake req_ready", W'(bus.req_ready), W'(1));
            @(posedge clk);
            #1;
            checkOutput("ignored request not taken", W'(bus.req_ready), W'(1));
        end
    endtask

    initial begin
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] r;
        int n;
        compared      = 0;
        mismatched    = 0;
        rst           = 1'b1;
        modelDone     = 1'b0;
        spuriousDone  = 1'b0;
        addNu         = 1'b0;
        modelEnable   = 1'b0;
        modelDelay    = 0;
        modelResult   = '0;
        bus.req_valid = 1'b0;
        bus.req_a     = '0;
        bus.req_b     = '0;
        bus.req_sel   = 2'b00;
        bus.rsp_ready = 1'b1;
        fork
            runMonitor();
            runAdder();
        join_none

        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        checkOutput("reset req_ready", W'(bus.req_ready), W'(1));
        checkOutput("reset nu_1", W'(bus.nu_1), W'(0));
        checkOutput("reset nu_2", W'(bus.nu_2), W'(0));
        checkOutput("reset start_add", W'(bus.start_add), W'(0));
        checkOutput("reset sel", W'(bus.sel), W'(0));
        checkOutput("reset rsp_valid", W'(bus.rsp_valid), W'(0));
        checkOutput("reset rsp_data", bus.rsp_data, '0);
        checkOutput("reset rsp_err", W'(bus.rsp_err), W'(0));
        @(posedge clk);
        #1;

        // 1 + 2 = 3, adder answers in the 5th WAIT cycle
        a = W'(1);
        b = W'(2);
        r = W'(3);
        applyStimulus(a, b, 2'b00, r, 1'b0, 5, -1, 1'b0);
        n = 0;
        while (!bus.rsp_valid && n < 4 * W) begin
            @(posedge clk);
            #1;
            n++;
        end
        checkOutput("START to rsp_valid cycles", W'(n), W'(W + 6));

        a = '1;
        b = '1;
        r = {(W / 8){8'hA5}};
        applyStimulus(a, b, 2'b01, r, 1'b0, 1, -1, 1'b0);

        // done_add during SHIFT must not start the capture early
        a = {8{32'h1357_9BDF}};
        b = {8{32'h0F0F_1234}};
        r = {4{64'hDEAD_BEEF_0BAD_F00D}};
        applyStimulus(a, b, 2'b10, r, 1'b0, 3, 10, 1'b0);

        a = {64{4'h3}};
        b = {64{4'hC}};
        r = {8{32'h8000_0001}};
        applyStimulus(a, b, 2'b11, r, 1'b0, 2, -1, 1'b1);

        // Reset while bit 100 is on the serial lines; the aborted request must never answer
        waitReady();
        modelEnable   = 1'b1;
        modelDelay    = 1;
        bus.req_a     = '1;
        bus.req_b     = '1;
        bus.req_sel   = 2'b01;
        bus.req_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        repeat (100) begin
            @(posedge clk);
            #1;
        end
        checkOutput("nu_1 at bit 100", W'(bus.nu_1), W'(1));
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        checkOutput("abort nu_1", W'(bus.nu_1), W'(0));
        checkOutput("abort nu_2", W'(bus.nu_2), W'(0));
        checkOutput("abort req_ready", W'(bus.req_ready), W'(1));
        checkOutput("abort start_add", W'(bus.start_add), W'(0));
        repeat (2 * W + 20) @(posedge clk);
        #1;
        checkOutput("abort rsp_valid", W'(bus.rsp_valid), W'(0));

        a = W'(5);
        b = W'(7);
        r = W'(12);
        applyStimulus(a, b, 2'b10, r, 1'b0, 2, -1, 1'b0);

`ifdef MOD_ADD_DRV_TIMEOUT_EN
        a = W'(9);
        b = W'(6);
        applyStimulus(a, b, 2'b01, '0, 1'b1, 0, -1, 1'b0);
        n = 0;
        while (!bus.rsp_valid && n < 4 * W) begin
            @(posedge clk);
            #1;
            n++;
        end
        checkOutput("watchdog START to rsp_valid", W'(n), W'(TO + 1));
        checkOutput("watchdog rsp_err", W'(bus.rsp_err), W'(1));
`endif

        n = 0;
        while (sbQ.size() != 0 && n < 4000) begin
            @(posedge clk);
            #1;
            n++;
        end
        checkOutput("scoreboard drained", W'(sbQ.size()), '0);
        repeat (5) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule

// File: doc/mod_add_serial_drv.md
MOD_ADD_SERIAL_DRV -- requirements
Module: mod_add_serial_drv

Interface
REQ-001 Parameter WIDTH, default 256: operand/result width in bits.
REQ-002 Parameter TIMEOUT, default 1024: done_add wait limit in cycles (Configuration only).
REQ-003 clk  in  1  sole clock; all state on its rising edge.
REQ-004 rst  in  1  asynchronous, active-high reset.
REQ-005 req_valid  in  1  operand request valid.
REQ-006 req_ready  out  1  driver idle, request accepted when req_valid&req_ready.
REQ-007 req_a, req_b  in  WIDTH  operands; req_sel  in  2  mode select.
REQ-008 nu_1, nu_2  out  1  serial operand bits to adder-side SIPOs.
REQ-009 sel  out  2  mode to adder; start_add  out  1  one-cycle start pulse.
REQ-010 add_nu  in  1  serial result bit; done_add  in  1  adder completion.
REQ-011 rsp_valid  out  1; rsp_ready  in  1; rsp_data  out  WIDTH; rsp_err  out  1.

Function
REQ-012 FSM states IDLE, SHIFT, START, WAIT, CAPT, RESP; req_ready=1 only in IDLE.
REQ-013 IDLE: on req_valid, latch req_a/req_b into shift registers, req_sel into sel, clear bit counter, go SHIFT.
REQ-014 SHIFT: exactly WIDTH cycles; each cycle nu_1/nu_2 = current LSB of a/b, registers shift right; bit 0 sent first.
REQ-015 Outside SHIFT, nu_1 and nu_2 SHALL be 0.
REQ-016 After bit WIDTH-1, one START cycle with start_add=1, then WAIT; start_add=0 in every other state.
REQ-017 sel held stable from acceptance until return to IDLE.
REQ-018 WAIT: on done_add=1 go CAPT next cycle; done_add outside WAIT ignored.
REQ-019 CAPT: exactly WIDTH cycles sampling add_nu, first sample cycle after done_add, LSB first, shifted in at MSB so rsp_data bit i = i-th sample.
REQ-020 RESP: rsp_valid=1, rsp_data/rsp_err stable until rsp_valid&rsp_ready, then IDLE; next request acceptable the following cycle.
REQ-021 Bit counter width $clog2(WIDTH)+1; no wrap within a phase; counter cleared at each phase entry.
REQ-022 Latency request-accept to rsp_valid: 2*WIDTH+3 cycles plus adder latency (done_add wait).
REQ-023 req_valid while not IDLE has no effect; operands not re-sampled.

Reset
REQ-024 rst=1 forces IDLE immediately, mid-operation included; abandoned transaction produces no response.
REQ-025 Reset values: req_ready=1 after reset release, nu_1=nu_2=0, start_add=0, sel=0, rsp_valid=0, rsp_data=0, rsp_err=0.

Configuration
REQ-026 Macro MOD_ADD_DRV_TIMEOUT_EN enables WAIT watchdog.
REQ-027 Defined: counter counts WAIT cycles; reaching TIMEOUT with no done_add goes to RESP with rsp_err=1, rsp_data=0, no CAPT.
REQ-028 Undefined: WAIT lasts indefinitely; rsp_err tied 0; no watchdog logic.

Verification
REQ-029 a=1, b=2, sel=0, adder model returns 3 after 5 cycles -> nu_1 high only on first SHIFT cycle, start_add at cycle WIDTH+1, rsp_data=3, rsp_err=0.
REQ-030 a=b=all-ones, returned serial pattern 0xA5..A5 -> rsp_data bit-exact 0xA5..A5; nu_2 high all WIDTH SHIFT cycles.
REQ-031 rsp_ready held 0 for 10 cycles -> rsp_valid/rsp_data stable, req_ready=0, second req_valid ignored.
REQ-032 rst pulsed mid-SHIFT at bit 100 -> next cycle nu_1=nu_2=0, req_ready=1, no rsp_valid ever for aborted request.
REQ-033 With MOD_ADD_DRV_TIMEOUT_EN, TIMEOUT=16, done_add never asserted -> rsp_valid 16 cycles into WAIT, rsp_err=1, rsp_data=0.
REQ-034 done_add pulsed during SHIFT then again in WAIT -> first ignored, capture starts after second.
